// File: rtl/apb_bridge_xbar.sv
// Native memory interface to APB4 bridge with a parameterised address map,
// per-access timeout, error responses and a local CSR window holding an
// interrupt aggregator and error capture registers.
module apb_bridge_xbar #(
  parameter int                      NUM_SLV   = 8,
  parameter logic [32*NUM_SLV-1:0]   SLV_BASE  = {NUM_SLV{32'h0}},
  parameter logic [32*NUM_SLV-1:0]   SLV_MASK  = {NUM_SLV{32'hFFFF_F000}},
  parameter logic [31:0]             CSR_BASE  = 32'h0300_F000,
  parameter int                      TIMEOUT   = 255,
  parameter int                      NUM_IRQ   = 8,
  parameter logic [NUM_IRQ-1:0]      IRQ_EDGE  = '0,
  parameter logic [31:0]             ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mem_valid_i,
  input  logic [31:0]             mem_addr_i,
  input  logic [31:0]             mem_wdata_i,
  input  logic [3:0]              mem_wstrb_i,
  output logic                    mem_ready_o,
  output logic [31:0]             mem_rdata_o,
  output logic [31:0]             paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    pwrite_o,
  output logic [31:0]             pwdata_o,
  output logic [3:0]              pstrb_o,
  output logic                    penable_o,
  output logic [NUM_SLV-1:0]      psel_o,
  input  logic [32*NUM_SLV-1:0]   prdata_i,
  input  logic [NUM_SLV-1:0]      pready_i,
  input  logic [NUM_SLV-1:0]      pslverr_i,
  input  logic [NUM_IRQ-1:0]      irq_src_i,
  output logic                    irq_o,
  output logic                    err_o
);

  localparam logic [31:0] CSR_MASK = 32'hFFFF_FFF0;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_LOCAL,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          addr_q, wdata_q, rdata_q;
  logic [3:0]           wstrb_q;
  logic                 write_q, err_q;
  logic [NUM_SLV-1:0]   sel_q;
  logic [15:0]          tcnt_q;

  logic                 csr_hit;
  logic [NUM_SLV-1:0]   slv_sel;
  logic                 sel_pready, sel_slverr, timeout_hit;
  logic [31:0]          sel_rdata;

  logic [NUM_IRQ-1:0]   irq_en_q, pend_e_q, src_q, src_d_q;
  logic [NUM_IRQ-1:0]   pend, rise, w1c, byte_mask, en_new;
  logic                 irq_q;
  logic [31:0]          err_addr_q, err_cnt_q, csr_rdata;
  logic                 csr_wr;
  logic [1:0]           csr_off;

  // Address decode: CSR window beats any slave, lowest-index slave wins overlaps.
  always_comb begin
    csr_hit = (mem_addr_i & CSR_MASK) == CSR_BASE;
    slv_sel = '0;
    // Walk downwards so the last hit written is the lowest index.
    for (int k = NUM_SLV - 1; k >= 0; k--) begin
      if ((mem_addr_i & SLV_MASK[32*k +: 32]) == SLV_BASE[32*k +: 32]) begin
        slv_sel    = '0;
        slv_sel[k] = 1'b1;
      end
    end
  end

  // Route the selected slave's response signals back to the bridge.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    sel_pready = 1'b0;
    sel_slverr = 1'b0;
    sel_rdata  = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (sel_q[k]) begin
        sel_pready = pready_i[k];
        sel_slverr = pslverr_i[k];
        sel_rdata  = prdata_i[32*k +: 32];
      end
    end
  end

  assign timeout_hit = (tcnt_q == TMO_LAST);

  // Next-state logic for the transfer sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mem_valid_i) begin
          // Decode misses turn around through LOCAL so every non-APB
          // response has the same two-cycle latency.
          if (csr_hit)         state_d = S_LOCAL;
          else if (|slv_sel)   state_d = S_SETUP;
          else                 state_d = S_LOCAL;
        end
      end
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (sel_pready || timeout_hit) state_d = S_RESP;
      S_LOCAL:  state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state always uses non-blocking assignments.
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Request capture, ACCESS timeout counter and response data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      tcnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_valid_i) begin
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
            wstrb_q <= mem_wstrb_i;
            write_q <= |mem_wstrb_i;
            sel_q   <= csr_hit ? '0 : slv_sel;
            err_q   <= !csr_hit && !(|slv_sel);
            tcnt_q  <= '0;
          end
        end
        S_ACCESS: begin
          if (sel_pready) begin
            rdata_q <= sel_rdata;
            err_q   <= sel_slverr;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
          end else begin
            tcnt_q  <= tcnt_q + 16'd1;
          end
        end
        S_LOCAL: if (!err_q) rdata_q <= csr_rdata;
        default: ;
      endcase
    end
  end

  // CSR decode helpers: write enable, word offset and byte-lane mask.
  always_comb begin
    csr_wr  = (state_q == S_LOCAL) && !err_q && write_q;
    csr_off = addr_q[3:2];
    for (int i = 0; i < NUM_IRQ; i++) byte_mask[i] = wstrb_q[i/8];
    en_new  = (irq_en_q & ~byte_mask) | (wdata_q[NUM_IRQ-1:0] & byte_mask);
    rise    = src_q & ~src_d_q & IRQ_EDGE;
    w1c     = (csr_wr && csr_off == 2'd1) ? (wdata_q[NUM_IRQ-1:0] & byte_mask & IRQ_EDGE) : '0;
    pend    = (pend_e_q & IRQ_EDGE) | (src_q & ~IRQ_EDGE);
    case (csr_off)
      2'd0:    csr_rdata = 32'(irq_en_q);
      2'd1:    csr_rdata = 32'(pend);
      2'd2:    csr_rdata = err_addr_q;
      default: csr_rdata = err_cnt_q;
    endcase
  end

  // Interrupt aggregator and error capture registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_en_q   <= '0;
      pend_e_q   <= '0;
      src_q      <= '0;
      src_d_q    <= '0;
      irq_q      <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      src_q    <= irq_src_i;
      src_d_q  <= src_q;
      // A new edge overrides a clear landing in the same cycle.
      pend_e_q <= (pend_e_q & ~w1c) | rise;
      irq_q    <= |(pend & irq_en_q);
      if (csr_wr && csr_off == 2'd0) irq_en_q <= en_new;
      if (state_q == S_RESP && err_q) begin
        err_addr_q <= addr_q;
        if (err_cnt_q != 32'hFFFF_FFFF) err_cnt_q <= err_cnt_q + 32'd1;
      end else if (csr_wr && csr_off == 2'd3) begin
        err_cnt_q <= '0;
      end
    end
  end

  assign mem_ready_o = (state_q == S_RESP);
  assign mem_rdata_o = (state_q != S_RESP) ? '0 : (err_q ? ERR_RDATA : rdata_q);
  assign err_o       = (state_q == S_RESP) && err_q;
  assign paddr_o     = addr_q;
  assign pprot_o     = 3'b000;
  assign pwrite_o    = write_q;
  assign pwdata_o    = wdata_q;
  assign pstrb_o     = wstrb_q;
  assign penable_o   = (state_q == S_ACCESS);
  assign psel_o      = (state_q == S_SETUP || state_q == S_ACCESS) ? sel_q : '0;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_apb_bridge_xbar.sv
// Directed self-checking bench for apb_bridge_xbar: APB transfers, decode
// priority, error paths, timeout, mid-transfer reset and the IRQ aggregator.
module tb_apb_bridge_xbar;

  localparam int NUM_SLV = 8;
  localparam int NUM_IRQ = 16;
  localparam logic [32*NUM_SLV-1:0] BASES = {
    32'h2000_7000, 32'h2000_6000, 32'h2000_5000, 32'h2000_4000,
    32'h1000_0000, 32'h1000_2000, 32'h1000_1000, 32'h1000_0000};
  localparam logic [32*NUM_SLV-1:0] MASKS = {
    32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000,
    32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};
  localparam logic [31:0] CSR = 32'h0300_F000;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   mem_valid_i;
  logic [31:0]            mem_addr_i, mem_wdata_i;
  logic [3:0]             mem_wstrb_i;
  logic                   mem_ready_o;
  logic [31:0]            mem_rdata_o, paddr_o, pwdata_o;
  logic [2:0]             pprot_o;
  logic                   pwrite_o, penable_o;
  logic [3:0]             pstrb_o;
  logic [NUM_SLV-1:0]     psel_o, pready_i, pslverr_i;
  logic [32*NUM_SLV-1:0]  prdata_i;
  logic [NUM_IRQ-1:0]     irq_src_i;
  logic                   irq_o, err_o;

  // Slave model controls.
  int          wait_cfg = 0;
  logic        hang = 1'b0;
  logic        slverr_cfg = 1'b0;
  logic [31:0] rdata_cfg = '0;
  int          acc_cnt;

  int compared = 0;
  int mismatched = 0;

  int          lat, en_cyc;
  logic [31:0] rd;
  logic        er, ok;
  logic [7:0]  seen;
  int          ready_cnt;

  apb_bridge_xbar #(
    .NUM_SLV(NUM_SLV), .SLV_BASE(BASES), .SLV_MASK(MASKS), .CSR_BASE(CSR),
    .TIMEOUT(6), .NUM_IRQ(NUM_IRQ), .IRQ_EDGE(16'h0001), .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_valid_i(mem_valid_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_wstrb_i(mem_wstrb_i), .mem_ready_o(mem_ready_o), .mem_rdata_o(mem_rdata_o),
    .paddr_o(paddr_o), .pprot_o(pprot_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
    .pstrb_o(pstrb_o), .penable_o(penable_o), .psel_o(psel_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .irq_src_i(irq_src_i), .irq_o(irq_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Slave model: counts ACCESS cycles and answers after wait_cfg wait states.
  always @(posedge clk_i) begin
    if (rst_i || !penable_o) acc_cnt <= 0;
    else                     acc_cnt <= acc_cnt + 1;
  end
  assign pready_i  = (penable_o && !hang && acc_cnt == wait_cfg) ? psel_o : '0;
  assign pslverr_i = slverr_cfg ? pready_i : '0;
  assign prdata_i  = {NUM_SLV{rdata_cfg}};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One NMI transfer starting at a falling edge; lat counts rising edges
  // from the sampling edge to the edge that raised mem_ready_o (-1 on timeout).
  task automatic nmi(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                     output int l, output logic [31:0] r, output logic e,
                     output logic [7:0] s, output int en, output logic good);
    logic first;
    mem_addr_i = a; mem_wdata_i = wd; mem_wstrb_i = st; mem_valid_i = 1'b1;
    l = -1; r = '0; e = 1'b0; s = '0; en = 0; good = 1'b1; first = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk_i);
      s |= psel_o;
      if (penable_o) en++;
      if (psel_o != '0) begin
        if (first && penable_o) good = 1'b0;
        first = 1'b0;
        if (paddr_o !== a || pwrite_o !== (|st) || pwdata_o !== wd || pstrb_o !== st)
          good = 1'b0;
      end
      if (mem_ready_o) begin
        l = c; r = mem_rdata_o; e = err_o;
        break;
      end
    end
    mem_valid_i = 1'b0;
    @(negedge clk_i);
    check("ready_single_pulse", {31'd0, mem_ready_o}, 32'd0);
  endtask

  task automatic csr_wr(input logic [1:0] off, input logic [31:0] d, input logic [3:0] st);
    int l, n; logic [31:0] r; logic e, g; logic [7:0] s;
    nmi(CSR + {28'd0, off, 2'b00}, d, st, l, r, e, s, n, g);
  endtask

  task automatic csr_rd(input logic [1:0] off, output logic [31:0] d);
    int l, n; logic e, g; logic [7:0] s;
    nmi(CSR + {28'd0, off, 2'b00}, 32'd0, 4'd0, l, d, e, s, n, g);
  endtask

  initial begin
    rst_i = 1'b1; mem_valid_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0;
    mem_wstrb_i = '0; irq_src_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_ready", {31'd0, mem_ready_o}, 32'd0);
    check("rst_psel", {24'd0, psel_o}, 32'd0);
    check("rst_penable", {31'd0, penable_o}, 32'd0);
    check("rst_rdata", mem_rdata_o, 32'd0);
    check("rst_irq_err", {30'd0, irq_o, err_o}, 32'd0);
    check("rst_paddr", paddr_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Zero-wait read from slave 2.
    rdata_cfg = 32'h1234_5678; wait_cfg = 0;
    nmi(32'h1000_2004, 32'd0, 4'd0, lat, rd, er, seen, en_cyc, ok);
    check("rd0_latency", lat, 32'd3);
    check("rd0_rdata", rd, 32'h1234_5678);
    check("rd0_err", {31'd0, er}, 32'd0);
    check("rd0_psel", {24'd0, seen}, 32'h04);
    check("rd0_setup_then_access", {31'd0, ok}, 32'd1);
    check("rd0_penable_cycles", en_cyc, 32'd1);

    // Write with five wait states; pready lands on the timeout cycle and wins.
    wait_cfg = 5;
    nmi(32'h1000_0010, 32'hA5A5_0000, 4'b1100, lat, rd, er, seen, en_cyc, ok);
    check("wr_latency", lat, 32'd8);
    check("wr_bus_stable", {31'd0, ok}, 32'd1);
    check("wr_psel", {24'd0, seen}, 32'h01);
    check("wr_penable_cycles", en_cyc, 32'd6);
    check("wr_no_err", {31'd0, er}, 32'd0);
    wait_cfg = 0;

    // Overlapping slaves 1 and 3: lowest index wins; slave 3 alone still reachable.
    rdata_cfg = 32'h0BAD_CAFE;
    nmi(32'h1000_1010, 32'd0, 4'd0, lat, rd, er, seen, en_cyc, ok);
    check("overlap_psel", {24'd0, seen}, 32'h02);
    nmi(32'h1000_8000, 32'd0, 4'd0, lat, rd, er, seen, en_cyc, ok);
    check("slv3_psel", {24'd0, seen}, 32'h08);
    check("slv3_rdata", rd, 32'h0BAD_CAFE);

    // Decode miss.
    nmi(32'hFFFF_0000, 32'h1111_2222, 4'hF, lat, rd, er, seen, en_cyc, ok);
    check("miss_latency", lat, 32'd2);
    check("miss_rdata", rd, 32'hDEAD_BEEF);
    check("miss_err", {31'd0, er}, 32'd1);
    check("miss_no_psel", {24'd0, seen}, 32'd0);
    csr_rd(2'd2, rd); check("err_addr_miss", rd, 32'hFFFF_0000);
    csr_rd(2'd3, rd); check("err_cnt_1", rd, 32'd1);

    // Timeout: slave never answers.
    hang = 1'b1;
    nmi(32'h2000_4000, 32'd0, 4'd0, lat, rd, er, seen, en_cyc, ok);
    check("tmo_penable_cycles", en_cyc, 32'd6);
    check("tmo_latency", lat, 32'd8);
    check("tmo_err", {31'd0, er}, 32'd1);
    check("tmo_rdata", rd, 32'hDEAD_BEEF);
    check("tmo_psel", {24'd0, seen}, 32'h10);
    hang = 1'b0;

    // Slave error.
    slverr_cfg = 1'b1;
    nmi(32'h2000_5000, 32'd0, 4'd0, lat, rd, er, seen, en_cyc, ok);
    check("slverr_latency", lat, 32'd3);
    check("slverr_err", {31'd0, er}, 32'd1);
    check("slverr_rdata", rd, 32'hDEAD_BEEF);
    slverr_cfg = 1'b0;
    csr_rd(2'd3, rd); check("err_cnt_3", rd, 32'd3);
    csr_rd(2'd2, rd); check("err_addr_slverr", rd, 32'h2000_5000);
    csr_wr(2'd2, 32'd0, 4'hF);
    csr_rd(2'd2, rd); check("err_addr_ro", rd, 32'h2000_5000);
    csr_wr(2'd3, 32'h1234_0000, 4'hF);
    csr_rd(2'd3, rd); check("err_cnt_clear", rd, 32'd0);

    // Reset in the middle of ACCESS abandons the transfer.
    hang = 1'b1;
    mem_addr_i = 32'h2000_6000; mem_wdata_i = '0; mem_wstrb_i = '0; mem_valid_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("pre_reset_in_access", {31'd0, penable_o}, 32'd1);
    rst_i = 1'b1; mem_valid_i = 1'b0;
    @(negedge clk_i);
    check("mid_reset_psel", {24'd0, psel_o}, 32'd0);
    check("mid_reset_penable", {31'd0, penable_o}, 32'd0);
    rst_i = 1'b0; hang = 1'b0;
    ready_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (mem_ready_o) ready_cnt++;
    end
    check("mid_reset_no_ready", ready_cnt, 32'd0);

    // IRQ enable: byte strobes and unimplemented bits.
    csr_wr(2'd0, 32'hFFFF_FFFF, 4'hF);
    csr_rd(2'd0, rd); check("irq_en_width", rd, 32'h0000_FFFF);
    csr_wr(2'd0, 32'h0000_AA03, 4'b0001);
    csr_rd(2'd0, rd); check("irq_en_strobe", rd, 32'h0000_FF03);
    csr_wr(2'd0, 32'h0000_0003, 4'hF);

    // Edge source 0: one-cycle pulse latches.
    irq_src_i = 16'h0001;
    @(negedge clk_i);
    irq_src_i = 16'h0000;
    repeat (4) @(negedge clk_i);
    check("edge_irq_o", {31'd0, irq_o}, 32'd1);
    csr_rd(2'd1, rd); check("edge_pend", rd, 32'h0000_0001);

    // W1C without a new edge clears.
    csr_wr(2'd1, 32'h0000_0001, 4'hF);
    repeat (3) @(negedge clk_i);
    csr_rd(2'd1, rd); check("w1c_clear", rd, 32'd0);
    check("w1c_irq_o", {31'd0, irq_o}, 32'd0);

    // W1C colliding with a new edge: set wins.
    irq_src_i = 16'h0001;
    csr_wr(2'd1, 32'h0000_0001, 4'hF);
    irq_src_i = 16'h0000;
    csr_rd(2'd1, rd); check("w1c_vs_set", rd, 32'h0000_0001);

    // Level source 1 follows the input.
    irq_src_i = 16'h0002;
    repeat (3) @(negedge clk_i);
    csr_rd(2'd1, rd); check("level_high", rd, 32'h0000_0003);
    check("irq_o_enabled", {31'd0, irq_o}, 32'd1);
    irq_src_i = 16'h0000;
    repeat (3) @(negedge clk_i);
    csr_rd(2'd1, rd); check("level_low", rd, 32'h0000_0001);

    // Disabling every source drops irq_o.
    csr_wr(2'd0, 32'd0, 4'hF);
    repeat (2) @(negedge clk_i);
    check("irq_o_disabled", {31'd0, irq_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
